// File: rtl/booth_mac_accum.sv
// Signed MAC reduction stage behind the radix-4 Booth multiplier: sums len products into a wide accumulator.
// Optional build macro BOOTH_MAC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module booth_mac_accum #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] count;
  logic             ovf;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic             ovf_now;
  logic [ACC_W-1:0] acc_nxt;
  logic             xfer;

  assign prod_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
  assign sum      = acc + prod_ext;
  assign ovf_now  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

  // On overflow both operands share a sign, so acc's sign picks the clamp direction.
`ifdef BOOTH_MAC_SATURATE_EN
  assign acc_nxt = ovf_now ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
  assign acc_nxt = sum;
`endif

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign acc_out   = acc;
  assign overflow  = ovf;
  assign xfer      = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= len;
            state <= (len == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc   <= acc_nxt;
            ovf   <= ovf | ovf_now;
            count <= count - 1'b1;
            if (count == {{(LEN_W-1){1'b0}}, 1'b1}) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mac_accum.sv
// Bench for booth_mac_accum (ACC_W=20): table vectors, hand-written handshake/reset sequences,
// and random operations checked against an integer-arithmetic reference model.
module tb_booth_mac_accum;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 20;
  localparam int LEN_W  = 8;
  localparam longint AMAX = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint AMIN = -(64'sd1 <<< (ACC_W-1));

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PROD_W-1:0] product = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  acc_out;
  logic              overflow;

  booth_mac_accum #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .product(product),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int pq[$];

  typedef struct packed {
    int                n;
    bit                tog;
    logic [19:0][15:0] p;
    int                exp_acc;
    bit                exp_ovf;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint acc_s();
    return longint'($signed(acc_out));
  endfunction

  // Reference: exact integer sum, out-of-range means overflow, then wrap or clamp.
  task automatic model(input int n, output longint a, output bit o);
    a = 0; o = 0;
    for (int i = 0; i < n; i++) begin
      a = a + longint'(pq[i]);
      if (a > AMAX || a < AMIN) begin
        o = 1;
`ifdef BOOTH_MAC_SATURATE_EN
        a = (a > AMAX) ? AMAX : AMIN;
`else
        a = (a > AMAX) ? a - (64'sd1 <<< ACC_W) : a + (64'sd1 <<< ACC_W);
`endif
      end
    end
  endtask

  // Start an op and feed pq; returns at the negedge where out_valid should be high.
  task automatic feed(input string name, input int n, input bit tog);
    int idx = 0;
    int cyc = 0;
    @(negedge clk); start = 1'b1; len = LEN_W'(n);
    @(negedge clk); start = 1'b0;
    while (idx < n && cyc < 200) begin
      chk({name, ".in_ready"}, longint'(in_ready), 1);
      if (!tog || (cyc % 2) == 0) begin
        in_valid = 1'b1; product = PROD_W'(pq[idx]); idx++;
      end else begin
        in_valid = 1'b0; product = $urandom;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (idx < n) begin
      nvec++; nerr++;
      $display("FAIL %s.timeout: got %0d transfers expected %0d", name, idx, n);
    end
  endtask

  task automatic result(input string name, input longint ea, input bit eo);
    chk({name, ".out_valid"}, longint'(out_valid), 1);
    chk({name, ".acc_out"}, acc_s(), ea);
    chk({name, ".overflow"}, longint'(overflow), longint'(eo));
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk({name, ".out_valid_drop"}, longint'(out_valid), 0);
  endtask

  initial begin
    longint ma;
    bit mo;
    int n;

    tbl[0] = '0; tbl[0].n = 3; tbl[0].p[0] = 16'd100; tbl[0].p[1] = -16'sd50; tbl[0].p[2] = 16'd7;
    tbl[0].exp_acc = 57; tbl[0].exp_ovf = 0;
    tbl[1] = '0; tbl[1].n = 17; for (int i = 0; i < 17; i++) tbl[1].p[i] = 16'd32767;
`ifdef BOOTH_MAC_SATURATE_EN
    tbl[1].exp_acc = 524287;
`else
    tbl[1].exp_acc = -491537;
`endif
    tbl[1].exp_ovf = 1;
    tbl[2] = '0; tbl[2].n = 4; tbl[2].tog = 1; for (int i = 0; i < 4; i++) tbl[2].p[i] = 16'h8000;
    tbl[2].exp_acc = -131072; tbl[2].exp_ovf = 0;
    tbl[3] = '0; tbl[3].n = 0; tbl[3].exp_acc = 0; tbl[3].exp_ovf = 0;
    tbl[4] = '0; tbl[4].n = 1; tbl[4].p[0] = 16'd9; tbl[4].exp_acc = 9; tbl[4].exp_ovf = 0;
    tbl[5] = '0; tbl[5].n = 17; for (int i = 0; i < 17; i++) tbl[5].p[i] = 16'h8000;
`ifdef BOOTH_MAC_SATURATE_EN
    tbl[5].exp_acc = -524288;
`else
    tbl[5].exp_acc = 491520;
`endif
    tbl[5].exp_ovf = 1;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset.in_ready", longint'(in_ready), 0);
    chk("reset.out_valid", longint'(out_valid), 0);
    chk("reset.acc_out", acc_s(), 0);
    chk("reset.overflow", longint'(overflow), 0);

    foreach (tbl[k]) begin
      pq.delete();
      for (int i = 0; i < tbl[k].n; i++) pq.push_back(int'($signed(tbl[k].p[i])));
      feed($sformatf("tbl%0d", k), tbl[k].n, tbl[k].tog);
      result($sformatf("tbl%0d", k), longint'(tbl[k].exp_acc), tbl[k].exp_ovf);
    end

    // Result held with out_ready low; start pulses must be ignored, including at the handshake.
    pq = '{5, 6};
    feed("hold", 2, 0);
    for (int c = 0; c < 5; c++) begin
      start = c[0]; len = 8'd3;
      @(negedge clk);
      chk("hold.out_valid", longint'(out_valid), 1);
      chk("hold.acc_out", acc_s(), 11);
    end
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0; out_ready = 1'b0;
    chk("hold.idle_out_valid", longint'(out_valid), 0);
    chk("hold.idle_in_ready", longint'(in_ready), 0);
    chk("hold.idle_acc_kept", acc_s(), 11);
    @(negedge clk);
    chk("hold.still_idle", longint'(in_ready), 0);

    // Reset after 2 of 5 transfers aborts the op.
    @(negedge clk); start = 1'b1; len = 8'd5;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; product = 16'd1000;
      @(negedge clk);
    end
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("abort.in_ready", longint'(in_ready), 0);
    chk("abort.out_valid", longint'(out_valid), 0);
    chk("abort.acc_out", acc_s(), 0);
    pq = '{9};
    feed("abort.new", 1, 0);
    result("abort.new", 9, 0);

    // Random operations vs. the reference model.
    for (int t = 0; t < 30; t++) begin
      n = $urandom_range(0, 20);
      pq.delete();
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0: pq.push_back(32767);
          1: pq.push_back(-32768);
          default: pq.push_back(int'($signed(16'($urandom))));
        endcase
      end
      model(n, ma, mo);
      feed($sformatf("rnd%0d", t), n, 1'($urandom));
      result($sformatf("rnd%0d", t), ma, mo);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
